// File: rtl/spatz_tcdm_pkg.sv
// Shared types for the TCDM bank arbiter: FSM state, response-tracker entry,
// and the index-width helper used to size requester indices.
package spatz_tcdm_pkg;

    localparam int unsigned TrackIdxWidth = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                     valid;
        logic [TrackIdxWidth-1:0] idx;
    } rsp_track_t;

    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 32'd1) ? 32'($clog2(num)) : 32'd1;
    endfunction

endpackage

// File: rtl/spatz_tcdm_rsp_tracker.sv
// Fixed-latency shift register carrying {valid, idx} of each bank handshake
// so the read response can be routed back to the requester that issued it.
module spatz_tcdm_rsp_tracker
    import spatz_tcdm_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  rsp_track_t push_i,
    output rsp_track_t pop_o
);

    rsp_track_t [Depth-1:0] stage_q;
    rsp_track_t [Depth-1:0] stage_d;

    always_comb begin : shift_next
        stage_d    = stage_q;
        stage_d[0] = push_i;
        for (int unsigned i = 1; i < Depth; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : shift_reg
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign pop_o = stage_q[Depth-1];

endmodule

// File: rtl/spatz_tcdm_bank_arbiter.sv
// Shares one TCDM bank between NumInp requesters: round-robin grant with
// lock-in while the bank stalls, starvation aging, response routing, conflict count.
module spatz_tcdm_bank_arbiter
    import spatz_tcdm_pkg::*;
#(
    parameter int unsigned NumInp                = 4,
    parameter int unsigned DataWidth             = 32,
    parameter type         payload_t             = logic,
    parameter int unsigned MemoryResponseLatency = 1,
    parameter int unsigned StarveLimit           = 8,
    parameter int unsigned IdxWidth              = idx_width(NumInp)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic     [NumInp-1:0]           req_valid_i,
    input  payload_t [NumInp-1:0]           req_data_i,
    output logic     [NumInp-1:0]           req_ready_o,
    output logic                            mem_valid_o,
    output payload_t                        mem_data_o,
    input  logic                            mem_ready_i,
    input  logic     [DataWidth-1:0]        mem_rdata_i,
    output logic     [NumInp-1:0]           rsp_valid_o,
    output logic     [DataWidth-1:0]        rsp_data_o,
    output logic     [31:0]                 conflict_cnt_o
);

    localparam int unsigned WaitWidth = $clog2(StarveLimit + 1);
    localparam logic [WaitWidth-1:0] StarveMax = WaitWidth'(StarveLimit);
    localparam logic [IdxWidth-1:0]  LastIdx   = IdxWidth'(NumInp - 1);
    localparam logic [IdxWidth:0]    NumInpExt = (IdxWidth+1)'(NumInp);

    arb_state_e                        state_q, state_d;
    logic [IdxWidth-1:0]               rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0]               locked_idx_q, locked_idx_d;
    logic [NumInp-1:0][WaitWidth-1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0]                       conflict_cnt_q, conflict_cnt_d;

    logic                starved_vld, rr_vld;
    logic [IdxWidth-1:0] starved_idx, rr_idx, grant;
    logic                mem_valid_int, handshake, multi_valid;
    rsp_track_t          rsp_push, rsp_pop;

    // Starved requesters beat the rotating priority; a locked grant beats both.
    always_comb begin : grant_sel
        logic [IdxWidth:0]   sum;
        logic [IdxWidth-1:0] cand;
        starved_vld = 1'b0;
        starved_idx = '0;
        rr_vld      = 1'b0;
        rr_idx      = '0;
        sum         = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NumInp; i++) begin
            if (!starved_vld && req_valid_i[i] && (wait_cnt_q[i] == StarveMax)) begin
                starved_vld = 1'b1;
                starved_idx = IdxWidth'(i);
            end
        end
        for (int unsigned k = 0; k < NumInp; k++) begin
            sum = {1'b0, rr_ptr_q} + (IdxWidth+1)'(k);
            if (sum >= NumInpExt) begin
                sum = sum - NumInpExt;
            end
            cand = sum[IdxWidth-1:0];
            if (!rr_vld && req_valid_i[cand]) begin
                rr_vld = 1'b1;
                rr_idx = cand;
            end
        end
        if (state_q == LOCKED) begin
            grant = locked_idx_q;
        end else if (starved_vld) begin
            grant = starved_idx;
        end else begin
            grant = rr_idx;
        end
    end

    assign mem_valid_int = (state_q == LOCKED) || (|req_valid_i);
    assign handshake     = mem_valid_int && mem_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin : state_reg
        if (!rst_ni) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            locked_idx_q   <= '0;
            wait_cnt_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            locked_idx_q   <= locked_idx_d;
            wait_cnt_q     <= wait_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    always_comb begin : next_state
        state_d      = state_q;
        locked_idx_d = locked_idx_q;
        rr_ptr_d     = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (mem_valid_int && !mem_ready_i) begin
                    state_d      = LOCKED;
                    locked_idx_d = grant;
                end
            end
            LOCKED: begin
                if (mem_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (handshake) begin
            rr_ptr_d = (grant == LastIdx) ? '0 : grant + IdxWidth'(1);
        end
    end

    always_comb begin : outputs
        req_ready_o = '0;
        mem_valid_o = 1'b0;
        mem_data_o  = '0;
        rsp_data_o  = '0;
        if (rst_ni) begin
            req_ready_o[grant] = handshake;
            mem_valid_o        = mem_valid_int;
            mem_data_o         = req_data_i[grant];
            rsp_data_o         = mem_rdata_i;
        end
    end

    // Aging: counts cycles spent waiting, cleared on grant or when valid drops.
    always_comb begin : aging_next
        wait_cnt_d = wait_cnt_q;
        for (int unsigned i = 0; i < NumInp; i++) begin
            if (!req_valid_i[i] || req_ready_o[i]) begin
                wait_cnt_d[i] = '0;
            end else if (wait_cnt_q[i] != StarveMax) begin
                wait_cnt_d[i] = wait_cnt_q[i] + WaitWidth'(1);
            end
        end
    end

    assign multi_valid = |(req_valid_i & (req_valid_i - NumInp'(1)));

    always_comb begin : conflict_next
        conflict_cnt_d = conflict_cnt_q;
        if (multi_valid && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;

    assign rsp_push.valid = handshake;
    assign rsp_push.idx   = TrackIdxWidth'(grant);

    spatz_tcdm_rsp_tracker #(
        .Depth (MemoryResponseLatency)
    ) i_rsp_tracker (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (rsp_push),
        .pop_o  (rsp_pop)
    );

    always_comb begin : rsp_route
        rsp_valid_o = '0;
        for (int unsigned i = 0; i < NumInp; i++) begin
            rsp_valid_o[i] = rst_ni && rsp_pop.valid && (rsp_pop.idx == TrackIdxWidth'(i));
        end
    end

    // A locked requester must hold its request until the bank accepts it.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == LOCKED) |-> req_valid_i[locked_idx_q])
        else $error("locked requester dropped valid");

endmodule

// File: tb/tb_spatz_tcdm_bank_arbiter.sv
// Bench for spatz_tcdm_bank_arbiter: directed scenarios plus random traffic
// against a behavioural arbiter model; latency-1 and latency-3 instances share stimulus.
module tb_spatz_tcdm_bank_arbiter;

    localparam int N  = 4;
    localparam int SL = 4;

    typedef logic [31:0] pl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid;
    pl_t  [3:0]  data;
    logic        mem_ready;
    logic [31:0] rdata;

    logic [3:0]  ready1, ready3, rspv1, rspv3;
    logic        mvalid1, mvalid3;
    pl_t         mdata1, mdata3;
    logic [31:0] rspd1, rspd3, cnt1, cnt3;

    int checks   = 0;
    int failures = 0;

    int          m_rr, m_lidx;
    bit          m_locked;
    int          m_wait[N];
    longint      m_conf;
    logic [3:0]  q1[$];
    logic [3:0]  q3[$];

    logic [3:0]  last_ready, last_rsp1, last_rsp3;
    logic        last_mvalid;
    logic [31:0] last_mdata, last_cnt;
    pl_t         lock_pl;

    always #5 clk = ~clk;

    spatz_tcdm_bank_arbiter #(
        .NumInp(N), .DataWidth(32), .payload_t(pl_t),
        .MemoryResponseLatency(1), .StarveLimit(SL)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_data_i(data),
        .req_ready_o(ready1), .mem_valid_o(mvalid1), .mem_data_o(mdata1),
        .mem_ready_i(mem_ready), .mem_rdata_i(rdata), .rsp_valid_o(rspv1),
        .rsp_data_o(rspd1), .conflict_cnt_o(cnt1)
    );

    spatz_tcdm_bank_arbiter #(
        .NumInp(N), .DataWidth(32), .payload_t(pl_t),
        .MemoryResponseLatency(3), .StarveLimit(SL)
    ) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_data_i(data),
        .req_ready_o(ready3), .mem_valid_o(mvalid3), .mem_data_o(mdata3),
        .mem_ready_i(mem_ready), .mem_rdata_i(rdata), .rsp_valid_o(rspv3),
        .rsp_data_o(rspd3), .conflict_cnt_o(cnt3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_lidx = 0;
        m_locked = 1'b0;
        m_conf = 0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
        q1 = {4'b0000};
        q3 = {4'b0000, 4'b0000, 4'b0000};
    endtask

    // One bus cycle: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic cycle(input logic [3:0] v, input logic rdy);
        int         g;
        logic       mv, hs;
        logic [3:0] eoh, e1, e3;
        valid = v;
        mem_ready = rdy;
        rdata = $urandom;
        if (m_locked) valid[m_lidx] = 1'b1;
        @(negedge clk);
        g = -1;
        if (m_locked) begin
            g = m_lidx;
        end else begin
            for (int i = 0; i < N; i++)
                if (g < 0 && valid[i] && m_wait[i] >= SL) g = i;
            for (int k = 0; k < N; k++)
                if (g < 0 && valid[(m_rr + k) % N]) g = (m_rr + k) % N;
        end
        mv  = m_locked || (valid != 4'b0000);
        hs  = mv && mem_ready;
        eoh = hs ? 4'(1 << g) : 4'b0000;
        e1  = q1.pop_front();
        e3  = q3.pop_front();
        chk("req_ready", 64'(ready1), 64'(eoh));
        chk("req_ready_l3", 64'(ready3), 64'(eoh));
        chk("mem_valid", 64'(mvalid1), 64'(mv));
        if (mv) chk("mem_data", 64'(mdata1), 64'(data[g]));
        chk("rsp_valid_l1", 64'(rspv1), 64'(e1));
        chk("rsp_valid_l3", 64'(rspv3), 64'(e3));
        chk("rsp_data", 64'(rspd1), 64'(rdata));
        chk("conflict_cnt", 64'(cnt1), 64'(m_conf));
        last_ready  = ready1;
        last_mvalid = mvalid1;
        last_mdata  = mdata1;
        last_rsp1   = rspv1;
        last_rsp3   = rspv3;
        last_cnt    = cnt1;
        if ($countones(valid) >= 2 && m_conf < 64'hFFFF_FFFF) m_conf++;
        for (int i = 0; i < N; i++) begin
            if (!valid[i] || eoh[i]) m_wait[i] = 0;
            else if (m_wait[i] < SL) m_wait[i]++;
        end
        if (hs) begin
            m_rr = (g + 1) % N;
            m_locked = 1'b0;
        end else if (mv) begin
            m_locked = 1'b1;
            m_lidx = g;
        end
        q1.push_back(eoh);
        q3.push_back(eoh);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (!valid[i] || eoh[i]) data[i] = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(ready1 | ready3), 64'd0);
        chk({tag, "_mvalid"}, 64'(mvalid1), 64'd0);
        chk({tag, "_mdata"}, 64'(mdata1), 64'd0);
        chk({tag, "_rspv"}, 64'(rspv1 | rspv3), 64'd0);
        chk({tag, "_rspd"}, 64'(rspd1), 64'd0);
        chk({tag, "_cnt"}, 64'(cnt1), 64'd0);
    endtask

    // Called at posedge+1; inputs are active while reset is low to prove gating.
    task automatic do_reset();
        rst_n = 1'b0;
        valid = 4'b1111;
        mem_ready = 1'b1;
        rdata = 32'hDEAD_BEEF;
        #2;
        check_reset_outputs("in_reset");
        @(negedge clk);
        valid = 4'b0000;
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        valid = 4'b0000;
        mem_ready = 1'b0;
        rdata = 32'h1234_5678;
        for (int i = 0; i < N; i++) data[i] = $urandom;
        model_reset();
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset with one response in flight, then first grant from a clean state.
        cycle(4'b0010, 1'b1);
        do_reset();
        cycle(4'b1111, 1'b1);
        chk("first_grant_after_reset", 64'(last_ready), 64'b0001);
        chk("dropped_rsp_l1", 64'(last_rsp1), 64'd0);
        cycle(4'b0000, 1'b0);
        chk("dropped_rsp_l3", 64'(last_rsp3), 64'd0);

        // Round robin over all four requesters.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(4'b1111, 1'b1);
            chk("rr_grant", 64'(last_ready), 64'(1 << (k % 4)));
        end
        cycle(4'b0000, 1'b0);
        chk("rr_conflicts", 64'(last_cnt), 64'd8);

        // Lock-in on requester 2 while requester 1 joins.
        lock_pl = data[2];
        cycle(4'b0100, 1'b0);
        chk("lock_stall_valid", 64'(last_mvalid), 64'd1);
        for (int k = 0; k < 3; k++) begin
            cycle(4'b0110, 1'b0);
            chk("lock_payload", 64'(last_mdata), 64'(lock_pl));
            chk("lock_no_ready", 64'(last_ready), 64'd0);
        end
        cycle(4'b0100, 1'b1);
        chk("lock_release_grant", 64'(last_ready), 64'b0100);
        cycle(4'b1010, 1'b1);
        chk("lock_next_grant", 64'(last_ready), 64'b1000);

        // Requester 3 ages behind a stalled grant to 0, then jumps the rr order.
        cycle(4'b0001, 1'b0);
        for (int k = 0; k < 3; k++) cycle(4'b1001, 1'b0);
        cycle(4'b1001, 1'b1);
        chk("starve_hs0", 64'(last_ready), 64'b0001);
        cycle(4'b1011, 1'b1);
        chk("starve_grant3", 64'(last_ready), 64'b1000);
        chk("starve_wait3_clear", 64'(dut.wait_cnt_q[3]), 64'd0);
        cycle(4'b0000, 1'b0);

        // Response routing through the latency-3 instance.
        cycle(4'b0010, 1'b1);
        cycle(4'b0001, 1'b1);
        chk("rsp_l1_route", 64'(last_rsp1), 64'b0010);
        cycle(4'b0100, 1'b1);
        cycle(4'b0000, 1'b0);
        chk("rsp_l3_plus3", 64'(last_rsp3), 64'b0010);
        cycle(4'b0000, 1'b0);
        chk("rsp_l3_plus4", 64'(last_rsp3), 64'b0001);
        cycle(4'b0000, 1'b0);
        chk("rsp_l3_plus5", 64'(last_rsp3), 64'b0100);

        // Single requester: same-cycle grant, no conflicts.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0001, 1'b1);
            chk("single_grant", 64'(last_ready), 64'b0001);
        end
        cycle(4'b0000, 1'b0);
        chk("single_conflicts", 64'(last_cnt), 64'd0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cycle(4'($urandom), ($urandom_range(0, 9) < 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
